// File: rtl/data_mem_pkg.sv
// Shared types and field positions for the data-memory fabric.
// The CPU address splits into region (21:20), region word offset (19:2) and IO index (6:2).
package data_mem_pkg;

    typedef enum logic [1:0] {
        REG_RAM  = 2'b00,
        REG_IO   = 2'b01,
        REG_VRAM = 2'b10,
        REG_NONE = 2'b11
    } region_e;

    localparam int REGION_HI = 21;
    localparam int REGION_LO = 20;
    localparam int OFFSET_HI = 19;
    localparam int WORD_LO   = 2;
    localparam int IO_IDX_W  = 5;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dp_bram.sv
// 32-bit byte-enable RAM, read-first on port A, independent read-only port B.
// No reset: contents and read registers are left to block-RAM inference.
module dp_bram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [3:0]    a_be,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wd,
    output logic [31:0]   a_q,
    input  logic [AW-1:0] b_addr,
    output logic [31:0]   b_q
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_q <= mem_q[a_addr];
            if (a_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (a_be[i]) begin
                        mem_q[a_addr][8*i +: 8] <= a_wd[8*i +: 8];
                    end
                end
            end
        end
        // Port B sees the pre-write word when it collides with a port-A write.
        b_q <= mem_q[b_addr];
    end

endmodule

// File: rtl/data_mem_map.sv
// CPU load/store fabric: decodes RAM / IO bank / VRAM, registers read responses
// and keeps a sticky flag for accesses that hit nothing.
module data_mem_map
    import data_mem_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int VRAM_WORDS = 4096,
    parameter int NUM_IO     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   A,
    input  logic [31:0]                   WD,
    input  logic                          WE,
    input  logic [3:0]                    BE,
    input  logic                          RE,
    output logic [31:0]                   RD,
    output logic                          rd_valid,
    output logic                          bus_err,
    input  logic [NUM_IO*32-1:0]          io_in,
    output logic [NUM_IO*32-1:0]          io_out,
    input  logic [$clog2(VRAM_WORDS)-1:0] vga_addr,
    output logic [31:0]                   vga_q
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int VAW = $clog2(VRAM_WORDS);

    region_e     region;
    logic [31:0] word;
    logic [31:0] idx;
    logic        ram_hit, vram_hit, io_out_hit, io_in_hit, mapped;
    logic [31:0] wmask;
    logic [31:0] io_rd;
    logic [31:0] ram_q, vram_q;

    logic [31:0] io_out_q [NUM_IO];
    logic [31:0] io_out_d [NUM_IO];
    logic [31:0] sync1_q  [NUM_IO];
    logic [31:0] sync1_d  [NUM_IO];
    logic [31:0] sync2_q  [NUM_IO];

    logic        rd_valid_q, rd_valid_d;
    logic        bus_err_q, bus_err_d;
    region_e     sel_q, sel_d;
    logic [31:0] io_rd_q, io_rd_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{A[31:REGION_HI+1], A[WORD_LO-1:0]};

    always_comb begin
        region     = region_e'(A[REGION_HI:REGION_LO]);
        word       = 32'(A[OFFSET_HI:WORD_LO]);
        idx        = 32'(A[WORD_LO+IO_IDX_W-1:WORD_LO]);
        ram_hit    = (region == REG_RAM)  && (word < 32'(RAM_WORDS));
        vram_hit   = (region == REG_VRAM) && (word < 32'(VRAM_WORDS));
        io_out_hit = (region == REG_IO)   && (idx < 32'(NUM_IO));
        io_in_hit  = (region == REG_IO)   && (idx >= 32'(NUM_IO)) && (idx < 32'(2*NUM_IO));
        mapped     = ram_hit || vram_hit || io_out_hit || io_in_hit;
        wmask      = be_mask(BE);
    end

    dp_bram #(.DEPTH(RAM_WORDS), .AW(RAW)) u_ram (
        .clk    (clk),
        .a_en   (ram_hit && (WE || RE)),
        .a_we   (WE),
        .a_be   (BE),
        .a_addr (word[RAW-1:0]),
        .a_wd   (WD),
        .a_q    (ram_q),
        .b_addr ({RAW{1'b0}}),
        .b_q    ()
    );

    dp_bram #(.DEPTH(VRAM_WORDS), .AW(VAW)) u_vram (
        .clk    (clk),
        .a_en   (vram_hit && (WE || RE)),
        .a_we   (WE),
        .a_be   (BE),
        .a_addr (word[VAW-1:0]),
        .a_wd   (WD),
        .a_q    (vram_q),
        .b_addr (vga_addr),
        .b_q    (vga_q)
    );

    // IO bank: output registers, two-stage input synchronizer and read select.
    always_comb begin
        io_rd = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            io_out_d[k] = io_out_q[k];
            sync1_d[k]  = io_in[32*k +: 32];
            if (WE && io_out_hit && (idx == 32'(k))) begin
                io_out_d[k] = (io_out_q[k] & ~wmask) | (WD & wmask);
            end
            if (idx == 32'(k)) begin
                io_rd = io_out_q[k];
            end
            if (idx == 32'(k + NUM_IO)) begin
                io_rd = sync2_q[k];
            end
        end
    end

    always_comb begin
        rd_valid_d = RE;
        sel_d      = mapped ? region : REG_NONE;
        io_rd_d    = RE ? io_rd : io_rd_q;
        bus_err_d  = bus_err_q || ((WE || RE) && !mapped);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            sel_q      <= REG_NONE;
            io_rd_q    <= '0;
            for (int k = 0; k < NUM_IO; k++) begin
                io_out_q[k] <= '0;
                sync1_q[k]  <= '0;
                sync2_q[k]  <= '0;
            end
        end else begin
            rd_valid_q <= rd_valid_d;
            bus_err_q  <= bus_err_d;
            sel_q      <= sel_d;
            io_rd_q    <= io_rd_d;
            for (int k = 0; k < NUM_IO; k++) begin
                io_out_q[k] <= io_out_d[k];
                sync1_q[k]  <= sync1_d[k];
                sync2_q[k]  <= sync1_q[k];
            end
        end
    end

    // The select travels with the request, so the mux always matches its data.
    always_comb begin
        RD = '0;
        if (rd_valid_q) begin
            case (sel_q)
                REG_RAM:  RD = ram_q;
                REG_IO:   RD = io_rd_q;
                REG_VRAM: RD = vram_q;
                default:  RD = '0;
            endcase
        end
    end

    assign rd_valid = rd_valid_q;
    assign bus_err  = bus_err_q;

    generate
        for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_io_out
            assign io_out[32*gi +: 32] = io_out_q[gi];
        end
    endgenerate

endmodule
